scene_sequencer: RTL
====================

// Module: scene_sequencer
// PURPOSE
//  Top-level game-mode controller. Sequences TITLE -> OVERWORLD <-> BATTLE
//  with frame-timed fade-to-black transitions. Gates player_controller via
//  player_en and consumes its one-cycle battle_trigger pulse. Drives scene_sel
//  to the pixel mux and fade_level to the colour-dimming stage.
// PARAMETERS
//  STEP_FRAMES  2   frames per fade_level step (>=1)
//  HOLD_FRAMES  30  frames held fully black between fade-out and fade-in (>=1)
// PORTS
//  vclk          in   1   pixel clock
//  reset         in   1   synchronous, active-high
//  hcount        in   11  VGA horizontal count
//  vcount        in   10  VGA vertical count
//  start_btn     in   1   debounced start button, level
//  battle_trigger in  1   1-cycle encounter pulse from player_controller
//  battle_done   in   1   1-cycle pulse from battle engine: battle finished
//  player_en     out  1   drives player_controller.start
//  battle_en     out  1   enables battle engine
//  scene_sel     out  2   0=title, 1=overworld, 2=battle (3 unused)
//  fade_level    out  4   0=full brightness .. 15=black
//  encounters    out  8   battles entered since reset, saturates at 255
// BEHAVIOUR
//  - Clock vclk; reset synchronous, active-high. All outputs registered.
//  - frame_tick = (hcount==0 && vcount==0); one vclk per frame.
//  - Reset values: state=TITLE, player_en=0, battle_en=0, scene_sel=0,
//    fade_level=0, encounters=0, dest=TITLE, counters=0, start edge reg=0.
//  - Reset wins over every event, including mid-fade; next cycle is TITLE.
//  - start_btn rising-edge detected internally; holding it = one event.
//  - States: TITLE, OVERWORLD, FADE_OUT, BLACK, FADE_IN, BATTLE.
//  - TITLE: start edge -> FADE_OUT, dest=OVERWORLD.
//  - OVERWORLD: player_en=1. battle_trigger -> FADE_OUT, dest=BATTLE,
//    encounters+1 (sat). player_en=0 from cycle after trigger. Start edge ignored.
//  - FADE_OUT: step counter counts frame_ticks; on every STEP_FRAMES-th tick
//    fade_level+1. Tick making fade_level 15 also enters BLACK and loads
//    scene_sel from dest. Duration 15*STEP_FRAMES ticks.
//  - BLACK: fade_level=15; after HOLD_FRAMES ticks -> FADE_IN.
//  - FADE_IN: every STEP_FRAMES-th tick fade_level-1; tick reaching 0 enters
//    dest state (OVERWORLD or BATTLE) same cycle.
//  - BATTLE: battle_en=1. battle_done -> FADE_OUT, dest=OVERWORLD; battle_en
//    drops next cycle.
//  - battle_trigger ignored outside OVERWORLD; battle_done ignored outside
//    BATTLE; start edge ignored outside TITLE. Same-cycle trigger+start in
//    OVERWORLD: trigger taken.
//  - Step/hold counters clear on every state entry; fade_level never wraps
//    (clamped 0..15).
//  - scene_sel changes only on BLACK entry (screen fully dark), never mid-fade.
//  - player_en and battle_en never high together; both 0 in fade/black/title.
// TESTING (STEP_FRAMES=1, HOLD_FRAMES=2, short frame counts)
//  1 reset -> TITLE, scene_sel=0, fade_level=0, player_en=0, encounters=0.
//  2 start pulse -> fade_level 1..15 over 15 ticks, scene_sel=1 on 15th,
//    2 black ticks, 15 ticks to 0, player_en=1 on 32nd tick.
//  3 battle_trigger in OVERWORLD -> player_en=0 next cycle, encounters=1,
//    scene_sel=2 at black, battle_en=1 after fade-in; battle_done -> back to
//    scene_sel=1, player_en=1.
//  4 battle_trigger in FADE_IN/BATTLE and battle_done in OVERWORLD -> no
//    state change, encounters unchanged.
//  5 start_btn held high 200 frames from reset -> exactly one transition.
//  6 reset asserted with fade_level=9 in FADE_IN -> next cycle TITLE, fade=0.

Source files
------------

// File: rtl/scene_if.sv
// Signal bundle between the scene sequencer and the video/game blocks around it.
interface scene_if;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        start_btn;
  logic        battle_trigger;
  logic        battle_done;
  logic        player_en;
  logic        battle_en;
  logic [1:0]  scene_sel;
  logic [3:0]  fade_level;
  logic [7:0]  encounters;

  modport master (
    output hcount, vcount, start_btn, battle_trigger, battle_done,
    input  player_en, battle_en, scene_sel, fade_level, encounters
  );

  modport slave (
    input  hcount, vcount, start_btn, battle_trigger, battle_done,
    output player_en, battle_en, scene_sel, fade_level, encounters
  );
endinterface

// File: rtl/scene_sequencer.sv
// Game-mode controller: TITLE -> OVERWORLD <-> BATTLE with frame-timed
// fade-to-black transitions; scene_sel only switches while the screen is dark.
module scene_sequencer #(
  parameter int STEP_FRAMES = 2,
  parameter int HOLD_FRAMES = 30
) (
  input logic   vclk,
  input logic   reset,
  scene_if.slave bus
);

  localparam logic [2:0] TITLE     = 3'd0;
  localparam logic [2:0] OVERWORLD = 3'd1;
  localparam logic [2:0] FADE_OUT  = 3'd2;
  localparam logic [2:0] BLACK     = 3'd3;
  localparam logic [2:0] FADE_IN   = 3'd4;
  localparam logic [2:0] BATTLE    = 3'd5;

  localparam int CW = 16;
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_FRAMES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_FRAMES - 1);

  logic [2:0]    state;
  logic [2:0]    dest;
  logic [CW-1:0] step_cnt;
  logic [CW-1:0] hold_cnt;
  logic [3:0]    fade_level;
  logic [1:0]    scene_sel;
  logic [7:0]    encounters;
  logic          player_en;
  logic          battle_en;
  logic          start_q;

  logic frame_tick;
  logic start_edge;

  assign frame_tick = (bus.hcount == 11'd0) && (bus.vcount == 10'd0);
  assign start_edge = bus.start_btn && !start_q;

  function automatic logic [1:0] sel_of(input logic [2:0] s);
    case (s)
      OVERWORLD: sel_of = 2'd1;
      BATTLE:    sel_of = 2'd2;
      default:   sel_of = 2'd0;
    endcase
  endfunction

  always_ff @(posedge vclk) begin
    if (reset) begin
      state      <= TITLE;
      dest       <= TITLE;
      step_cnt   <= '0;
      hold_cnt   <= '0;
      fade_level <= 4'd0;
      scene_sel  <= 2'd0;
      encounters <= 8'd0;
      player_en  <= 1'b0;
      battle_en  <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      start_q <= bus.start_btn;
      case (state)
        TITLE: begin
          player_en <= 1'b0;
          battle_en <= 1'b0;
          if (start_edge) begin
            state    <= FADE_OUT;
            dest     <= OVERWORLD;
            step_cnt <= '0;
            hold_cnt <= '0;
          end
        end

        OVERWORLD: begin
          // Encounter wins over a simultaneous start press; start is ignored here.
          if (bus.battle_trigger) begin
            state     <= FADE_OUT;
            dest      <= BATTLE;
            player_en <= 1'b0;
            step_cnt  <= '0;
            hold_cnt  <= '0;
            if (encounters != 8'hFF) encounters <= encounters + 8'd1;
          end
        end

        FADE_OUT: begin
          if (frame_tick) begin
            if (step_cnt >= STEP_LAST) begin
              step_cnt <= '0;
              if (fade_level != 4'd15) fade_level <= fade_level + 4'd1;
              // The step that reaches full black is where the scene swaps.
              if (fade_level >= 4'd14) begin
                state     <= BLACK;
                scene_sel <= sel_of(dest);
                hold_cnt  <= '0;
              end
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end

        BLACK: begin
          fade_level <= 4'd15;
          if (frame_tick) begin
            if (hold_cnt >= HOLD_LAST) begin
              state    <= FADE_IN;
              step_cnt <= '0;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end

        FADE_IN: begin
          if (frame_tick) begin
            if (step_cnt >= STEP_LAST) begin
              step_cnt <= '0;
              if (fade_level != 4'd0) fade_level <= fade_level - 4'd1;
              if (fade_level <= 4'd1) begin
                state    <= dest;
                hold_cnt <= '0;
                if (dest == BATTLE) battle_en <= 1'b1;
                else                player_en <= 1'b1;
              end
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end

        BATTLE: begin
          if (bus.battle_done) begin
            state     <= FADE_OUT;
            dest      <= OVERWORLD;
            battle_en <= 1'b0;
            step_cnt  <= '0;
            hold_cnt  <= '0;
          end
        end

        default: begin
          state     <= TITLE;
          player_en <= 1'b0;
          battle_en <= 1'b0;
        end
      endcase
    end
  end

  assign bus.player_en  = player_en;
  assign bus.battle_en  = battle_en;
  assign bus.scene_sel  = scene_sel;
  assign bus.fade_level = fade_level;
  assign bus.encounters = encounters;

endmodule
